// File: rtl/dram_responder.sv
// dram_responder: MEM-stage data memory with byte-lane stores and a 1+WAIT_STATES cycle raw-word response
module dram_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_sl_type_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o
);
  localparam int CW = WAIT_STATES > 1 ? $clog2(WAIT_STATES + 1) : 1;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [31:0] hold_rdata, rd, wd;
  logic hold_err, accept, is_load, is_store, misaligned, err;
  logic [3:0] t, be;
  logic [ADDR_WIDTH-1:0] idx;
  logic unused_addr;
  assign unused_addr = ^req_addr_i[31:ADDR_WIDTH+2];
  assign req_ready_o = !rst && state == IDLE;
  assign busy_o = state == WAIT;
  always_comb begin
    t = req_sl_type_i;
    idx = req_addr_i[ADDR_WIDTH+1:2];
    accept = req_valid_i && req_ready_o;
    is_load = t >= 4'd1 && t <= 4'd5;
    is_store = t >= 4'd6 && t <= 4'd8;
    misaligned = (t == 4'd2 || t == 4'd5 || t == 4'd7) ? req_addr_i[0] :
                 (t == 4'd3 || t == 4'd8) ? |req_addr_i[1:0] : 1'b0;
    err = !(is_load || is_store) || misaligned;
    be = t == 4'd6 ? 4'b0001 << req_addr_i[1:0] :
         t == 4'd7 ? (req_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd = t == 4'd6 ? {4{req_wdata_i[7:0]}} :
         t == 4'd7 ? {2{req_wdata_i[15:0]}} : req_wdata_i;
    rd = (is_load && !err) ? mem[idx] : 32'd0;
  end
  always_ff @(posedge clk)
    if (accept && is_store && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o <= 1'b0;
      hold_rdata <= '0;
      hold_err <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      if (accept) begin
        hold_rdata <= rd;
        hold_err <= err;
        if (WAIT_STATES == 0) begin
          rsp_valid_o <= 1'b1;
          rsp_rdata_o <= rd;
          rsp_err_o <= err;
        end else begin
          state <= WAIT;
          cnt <= CW'(WAIT_STATES);
        end
      end else if (state == WAIT) begin
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          state <= IDLE;
          rsp_valid_o <= 1'b1;
          rsp_rdata_o <= hold_rdata;
          rsp_err_o <= hold_err;
        end
      end
    end
  end
endmodule

// File: tb/tb_dram_responder.sv
// tb_dram_responder: scoreboard bench for dram_responder with zero and two wait states
module tb_dram_responder;
  logic clk = 1'b0, rst = 1'b1, v0 = 1'b0, v2 = 1'b0;
  logic [3:0] sl = 4'd0;
  logic [31:0] addr = '0, wdata = '0;
  logic rdy0, rv0, re0, bz0, rdy2, rv2, re2, bz2;
  logic [31:0] rd0, rd2;
  logic [32:0] q0[$], q2[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  dram_responder #(.ADDR_WIDTH(12), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid_i(v0), .req_ready_o(rdy0), .req_addr_i(addr),
    .req_wdata_i(wdata), .req_sl_type_i(sl), .rsp_valid_o(rv0), .rsp_rdata_o(rd0),
    .rsp_err_o(re0), .busy_o(bz0));
  dram_responder #(.ADDR_WIDTH(12), .WAIT_STATES(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid_i(v2), .req_ready_o(rdy2), .req_addr_i(addr),
    .req_wdata_i(wdata), .req_sl_type_i(sl), .rsp_valid_o(rv2), .rsp_rdata_o(rd2),
    .rsp_err_o(re2), .busy_o(bz2));
  task automatic monitor();
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rv0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL rsp0_unexpected got err=%0b rdata=%h required none", re0, rd0);
        end else begin
          e = q0.pop_front();
          if ({re0, rd0} !== e) begin
            errors++;
            $display("FAIL rsp0 got err=%0b rdata=%h required err=%0b rdata=%h", re0, rd0, e[32], e[31:0]);
          end
        end
      end
      if (rv2) begin
        checks++;
        if (q2.size() == 0) begin
          errors++;
          $display("FAIL rsp2_unexpected got err=%0b rdata=%h required none", re2, rd2);
        end else begin
          e = q2.pop_front();
          if ({re2, rd2} !== e) begin
            errors++;
            $display("FAIL rsp2 got err=%0b rdata=%h required err=%0b rdata=%h", re2, rd2, e[32], e[31:0]);
          end
        end
      end
    end
  endtask
  task automatic issue(input bit s, input logic [3:0] t, input logic [31:0] a, input logic [31:0] d,
                       input bit push, input bit ee, input logic [31:0] er);
    int n = 0;
    @(negedge clk);
    sl = t; addr = a; wdata = d;
    if (s) v2 = 1'b1; else v0 = 1'b1;
    while (!(s ? rdy2 : rdy0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n == 20) begin
      errors++;
      $display("FAIL accept_timeout got ready=0 required ready=1 within 20 cycles");
    end
    if (push) begin
      if (s) q2.push_back({ee, er}); else q0.push_back({ee, er});
    end
    @(posedge clk);
    #1;
    v0 = 1'b0; v2 = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rdy0, rv0, re0, bz0, rd0} !== 36'd0) begin
      errors++;
      $display("FAIL reset0 got rdy=%0b v=%0b e=%0b b=%0b d=%h required all 0", rdy0, rv0, re0, bz0, rd0);
    end
    checks++;
    if ({rdy2, rv2, re2, bz2, rd2} !== 36'd0) begin
      errors++;
      $display("FAIL reset2 got rdy=%0b v=%0b e=%0b b=%0b d=%h required all 0", rdy2, rv2, re2, bz2, rd2);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({rdy0, rdy2} !== 2'b11) begin
      errors++;
      $display("FAIL ready_after_reset got %b required 11", {rdy0, rdy2});
    end
  endtask
  task automatic test_back_to_back();
    @(negedge clk);
    sl = 4'd8; addr = 32'h100; wdata = 32'hDEADBEEF; v0 = 1'b1;
    q0.push_back({1'b0, 32'd0});
    @(posedge clk);
    #1;
    checks++;
    if (rv0 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first got rsp_valid=%0b required 1", rv0);
    end
    sl = 4'd3; addr = 32'h100;
    q0.push_back({1'b0, 32'hDEADBEEF});
    @(posedge clk);
    #1;
    v0 = 1'b0;
    checks++;
    if (rv0 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second got rsp_valid=%0b required 1", rv0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rv0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pulse got rsp_valid=%0b required 0", rv0);
    end
  endtask
  task automatic test_lanes();
    issue(0, 4'd8, 32'h200, 32'h0, 1, 0, 32'h0);
    issue(0, 4'd6, 32'h202, 32'hFFFFFF5A, 1, 0, 32'h0);
    issue(0, 4'd7, 32'h200, 32'hFFFF1234, 1, 0, 32'h0);
    issue(0, 4'd3, 32'h200, 32'h0, 1, 0, 32'h005A1234);
  endtask
  task automatic test_misalign();
    issue(0, 4'd3, 32'h103, 32'h0, 1, 1, 32'h0);
    issue(0, 4'd7, 32'h201, 32'hFFFF, 1, 1, 32'h0);
    issue(0, 4'd8, 32'h202, 32'h77777777, 1, 1, 32'h0);
    issue(0, 4'd3, 32'h200, 32'h0, 1, 0, 32'h005A1234);
    issue(0, 4'd2, 32'h202, 32'h0, 1, 0, 32'h005A1234);
    issue(0, 4'd4, 32'h203, 32'h0, 1, 0, 32'h005A1234);
    issue(0, 4'd5, 32'h203, 32'h0, 1, 1, 32'h0);
  endtask
  task automatic test_alias_illegal();
    issue(0, 4'd8, 32'h4000, 32'hCAFEF00D, 1, 0, 32'h0);
    issue(0, 4'd3, 32'h0, 32'h0, 1, 0, 32'hCAFEF00D);
    issue(0, 4'd9, 32'h0, 32'h12345678, 1, 1, 32'h0);
    issue(0, 4'd0, 32'h0, 32'h12345678, 1, 1, 32'h0);
    issue(0, 4'd3, 32'hFFFF_C000, 32'h0, 1, 0, 32'hCAFEF00D);
  endtask
  task automatic test_wait_states();
    issue(1, 4'd8, 32'h300, 32'h11223344, 1, 0, 32'h0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    sl = 4'd3; addr = 32'h302; v2 = 1'b1;
    q2.push_back({1'b1, 32'h0});
    @(posedge clk);
    #1;
    v2 = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      checks++;
      if ({rdy2, rv2, bz2} !== 3'b001) begin
        errors++;
        $display("FAIL wait_cycle%0d got rdy/v/busy=%b required 001", k, {rdy2, rv2, bz2});
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if ({rdy2, rv2, bz2} !== 3'b110) begin
      errors++;
      $display("FAIL wait_rsp got rdy/v/busy=%b required 110", {rdy2, rv2, bz2});
    end
    sl = 4'd3; addr = 32'h300; v2 = 1'b1;
    q2.push_back({1'b0, 32'h11223344});
    @(posedge clk);
    #1;
    v2 = 1'b0;
    for (int k = 4; k <= 5; k++) begin
      checks++;
      if ({rdy2, rv2} !== 2'b00) begin
        errors++;
        $display("FAIL overlap_cycle%0d got rdy/v=%b required 00", k, {rdy2, rv2});
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if ({rv2, rd2} !== {1'b1, 32'h11223344}) begin
      errors++;
      $display("FAIL overlap_rsp got v=%0b d=%h required v=1 d=11223344", rv2, rd2);
    end
  endtask
  task automatic test_reset_mid_op();
    issue(1, 4'd3, 32'h300, 32'h0, 0, 0, 32'h0);
    rst = 1'b1;
    #1;
    checks++;
    if (rdy2 !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_rst got %0b required 0", rdy2);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({rv2, bz2, re2, rd2} !== 35'd0) begin
      errors++;
      $display("FAIL mid_rst got v=%0b b=%0b e=%0b d=%h required all 0", rv2, bz2, re2, rd2);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (rdy2 !== 1'b1) begin
      errors++;
      $display("FAIL ready_release got %0b required 1", rdy2);
    end
    repeat (6) @(posedge clk);
    issue(1, 4'd3, 32'h300, 32'h0, 1, 0, 32'h11223344);
  endtask
  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_back_to_back();
    test_lanes();
    test_misalign();
    test_alias_illegal();
    test_wait_states();
    test_reset_mid_op();
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (q0.size() + q2.size() != 0) begin
      errors++;
      $display("FAIL pending_rsp got %0d outstanding required 0", q0.size() + q2.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
